// File: rtl/cla_pipe.sv
// rtl/cla_pipe.sv - pipelined carry-lookahead adder/subtractor, one carry group per stage
module cla_pipe #(
  parameter int WIDTH = 16,
  parameter int GRP   = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             Cin_in,
  input  logic             SUB_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] S_out,
  output logic             Cout_out,
  output logic             OVF_out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NGRP = WIDTH / GRP;

  // Stage s holds operands, partially resolved sum, carry into the next
  // unresolved group, and (once known) the carry into the MSB.
  logic [WIDTH-1:0] a_q     [0:NGRP-1];
  logic [WIDTH-1:0] b_q     [0:NGRP-1];
  logic [WIDTH-1:0] sum_q   [0:NGRP];
  logic             carry_q [0:NGRP];
  logic             cmsb_q  [0:NGRP];
  logic             valid_q [0:NGRP];

  logic [WIDTH-1:0] sum_d   [1:NGRP];
  logic             carry_d [1:NGRP];
  logic             cmsb_d  [1:NGRP];

  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic             stall;

  // Sum-of-products lookahead: every carry in the group is a flat function
  // of the group's g/p bits and the group carry-in.
  function automatic logic [GRP:0] group_carries(input logic [GRP-1:0] g,
                                                 input logic [GRP-1:0] p,
                                                 input logic           c0);
    logic [GRP:0] c;
    logic         term;
    logic         prod;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < GRP; i++) begin
      term = g[i];
      prod = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (prod & g[j]);
        prod = prod & p[j];
      end
      c[i+1] = term | (prod & c0);
    end
    return c;
  endfunction

  assign stall     = out_valid_q & ~out_ready;
  assign in_ready  = ~stall;
  assign S_out     = s_q;
  assign Cout_out  = cout_q;
  assign OVF_out   = ovf_q;
  assign out_valid = out_valid_q;

  // Stage k+1 resolves group k from stage k's operands and group carry.
  always_comb begin
    logic [GRP-1:0] gg;
    logic [GRP-1:0] pp;
    logic [GRP:0]   cc;
    gg = '0;
    pp = '0;
    cc = '0;
    for (int s = 1; s <= NGRP; s++) begin
      sum_d[s]   = '0;
      carry_d[s] = 1'b0;
      cmsb_d[s]  = 1'b0;
    end
    for (int k = 0; k < NGRP; k++) begin
      gg = a_q[k][k*GRP +: GRP] & b_q[k][k*GRP +: GRP];
      pp = a_q[k][k*GRP +: GRP] ^ b_q[k][k*GRP +: GRP];
      cc = group_carries(gg, pp, carry_q[k]);
      sum_d[k+1]                = sum_q[k];
      sum_d[k+1][k*GRP +: GRP]  = pp ^ cc[GRP-1:0];
      carry_d[k+1]              = cc[GRP];
      cmsb_d[k+1]               = (k == NGRP - 1) ? cc[GRP-1] : cmsb_q[k];
    end
  end

  // Data path advances as a unit unless the output is stalled; no reset needed.
  always_ff @(posedge CLK) begin
    if (!stall) begin
      if (in_valid) begin
        a_q[0]     <= A_in;
        b_q[0]     <= SUB_in ? ~B_in : B_in;
        carry_q[0] <= SUB_in ? 1'b1 : Cin_in;
        sum_q[0]   <= '0;
        cmsb_q[0]  <= 1'b0;
      end
      for (int s = 1; s < NGRP; s++) begin
        a_q[s] <= a_q[s-1];
        b_q[s] <= b_q[s-1];
      end
      for (int s = 1; s <= NGRP; s++) begin
        sum_q[s]   <= sum_d[s];
        carry_q[s] <= carry_d[s];
        cmsb_q[s]  <= cmsb_d[s];
      end
    end
  end

  // Valid bits and result registers: cleared by reset, frozen during a stall.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int s = 0; s <= NGRP; s++) valid_q[s] <= 1'b0;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (!stall) begin
      valid_q[0] <= in_valid;
      for (int s = 1; s <= NGRP; s++) valid_q[s] <= valid_q[s-1];
      out_valid_q <= valid_q[NGRP];
      if (valid_q[NGRP]) begin
        s_q    <= sum_q[NGRP];
        cout_q <= carry_q[NGRP];
        ovf_q  <= carry_q[NGRP] ^ cmsb_q[NGRP];
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe.sv
// tb/tb_cla_pipe.sv - directed self-checking bench for cla_pipe
module tb_cla_pipe;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] A_in, B_in, S_out;
  logic        Cin_in, SUB_in, in_valid, in_ready, Cout_out, OVF_out, out_valid, out_ready;

  logic [7:0]  a8, b8, s8;
  logic        cin8, sub8, iv8, ir8, co8, ov8, ovld8, ordy8;

  always #5 CLK = ~CLK;

  cla_pipe #(.WIDTH(16), .GRP(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .A_in(A_in), .B_in(B_in), .Cin_in(Cin_in),
    .SUB_in(SUB_in), .in_valid(in_valid), .in_ready(in_ready), .S_out(S_out),
    .Cout_out(Cout_out), .OVF_out(OVF_out), .out_valid(out_valid), .out_ready(out_ready)
  );

  cla_pipe #(.WIDTH(8), .GRP(8)) dut8 (
    .CLK(CLK), .RST_N(RST_N), .A_in(a8), .B_in(b8), .Cin_in(cin8),
    .SUB_in(sub8), .in_valid(iv8), .in_ready(ir8), .S_out(s8),
    .Cout_out(co8), .OVF_out(ov8), .out_valid(ovld8), .out_ready(ordy8)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [17:0] obs_q[$];
  int          obs_cyc[$];
  logic [17:0] exp_q[$];

  always @(posedge CLK) cyc++;

  // A result is consumed on the edge following a sample with valid and ready high.
  always @(negedge CLK) begin
    #1;
    if (RST_N && out_valid && out_ready) begin
      obs_q.push_back({OVF_out, Cout_out, S_out});
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference: plain wide addition, overflow from operand/result signs.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [15:0] bb;
    logic [16:0] r;
    logic        ovf;
    bb  = sub ? ~b : b;
    r   = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
    ovf = (a[15] == bb[15]) && (r[15] != a[15]);
    return {ovf, r[16], r[15:0]};
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub, input logic push, input logic [17:0] e,
                       output logic acc);
    @(negedge CLK);
    A_in = a; B_in = b; Cin_in = cin; SUB_in = sub; in_valid = 1'b1;
    #1;
    acc = in_ready;
    if (acc && push) exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      in_valid = 1'b0;
    end
  endtask

  task automatic compare_results(input string tag);
    int n;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    logic        acc;
    int          lat;
    int          nacc;
    int          gaps;
    logic [15:0] ra, rb;
    logic [15:0] snap;

    RST_N = 1'b0; A_in = '0; B_in = '0; Cin_in = 1'b0; SUB_in = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b0; ordy8 = 1'b1;

    @(negedge CLK); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s_out", S_out, 0);
    chk("rst_flags", {Cout_out, OVF_out}, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    chk("rst_release_in_ready", in_ready, 1);

    // Latency of a single transaction.
    @(negedge CLK);
    A_in = 16'h1234; B_in = 16'h4321; Cin_in = 1'b0; SUB_in = 1'b0; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge CLK); lat++; #1;
      if (out_valid) break;
    end
    chk("lat16", lat, 5);
    chk("lat16_sum", S_out, 16'h5555);
    chk("lat16_flags", {Cout_out, OVF_out}, 2'b00);
    idle(4);
    obs_q.delete(); obs_cyc.delete();

    // Carry/overflow/borrow corners, hand-computed.
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, {1'b0, 1'b1, 16'h0000}, acc);
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, {1'b1, 1'b0, 16'h8000}, acc);
    drive(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE}, acc);
    drive(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, {1'b1, 1'b1, 16'h7FFF}, acc);
    drive(16'h0010, 16'h0010, 1'b1, 1'b1, 1'b1, {1'b0, 1'b1, 16'h0000}, acc);
    drive(16'h00FF, 16'h0F00, 1'b1, 1'b0, 1'b1, {1'b0, 1'b0, 16'h1000}, acc);
    drive(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, {1'b1, 1'b1, 16'h0000}, acc);
    idle(10);
    compare_results("corner");

    // Twenty back-to-back operations, one result per cycle.
    for (int i = 0; i < 20; i++) begin
      ra = 16'(i * 16'h1357 + 16'h0F0F);
      rb = 16'(16'hFEDC - i * 16'h0321);
      drive(ra, rb, i[1], i[0], 1'b1, model(ra, rb, i[1], i[0]), acc);
    end
    idle(10);
    gaps = 0;
    for (int i = 1; i < obs_cyc.size(); i++)
      if (obs_cyc[i] - obs_cyc[i-1] != 1) gaps++;
    chk("b2b_gaps", gaps, 0);
    compare_results("b2b");

    // Stall: output held, pipeline fills to NGRP+2 results, then drains in order.
    @(negedge CLK);
    out_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      ra = 16'(16'h1111 * (i + 1));
      rb = 16'(16'h0F0F + i);
      drive(ra, rb, 1'b1, 1'b0, 1'b1, model(ra, rb, 1'b1, 1'b0), acc);
      if (acc) nacc++;
    end
    @(negedge CLK);
    in_valid = 1'b0;
    #1;
    chk("stall_accepted", nacc, 6);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_first", {OVF_out, Cout_out, S_out}, model(16'h1111, 16'h0F0F, 1'b1, 1'b0));
    snap = S_out;
    repeat (3) @(negedge CLK);
    #1;
    chk("stall_hold", S_out, snap);
    @(negedge CLK);
    out_ready = 1'b1;
    idle(12);
    compare_results("stall");

    // Reset with three transactions in flight.
    drive(16'h0101, 16'h0202, 1'b0, 1'b0, 1'b0, 18'h0, acc);
    drive(16'h0303, 16'h0404, 1'b0, 1'b0, 1'b0, 18'h0, acc);
    drive(16'h0505, 16'h0606, 1'b0, 1'b0, 1'b0, 18'h0, acc);
    @(negedge CLK);
    in_valid = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_s_out", S_out, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge CLK);
    RST_N = 1'b1;
    idle(10);
    chk("midrst_no_stale", obs_q.size(), 0);
    obs_q.delete(); obs_cyc.delete();

    // Single-group configuration: latency 2.
    @(negedge CLK);
    a8 = 8'h12; b8 = 8'h43; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
    @(posedge CLK); #1;
    iv8 = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge CLK); lat++; #1;
      if (ovld8) break;
    end
    chk("lat8", lat, 2);
    chk("lat8_sum", {ov8, co8, s8}, {1'b0, 1'b0, 8'h55});
    @(negedge CLK);
    a8 = 8'h7F; b8 = 8'h01; iv8 = 1'b1;
    @(posedge CLK); #1;
    iv8 = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    chk("w8_ovf", {ovld8, ov8, co8, s8}, {1'b1, 1'b1, 1'b0, 8'h80});

    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
